dft_twiddle_sequencer: RTL and testbench
========================================

# dft_twiddle_sequencer

- Upstream feeder for the CORDIC rotation stage in the DFT datapath.
- Buffers one frame of N complex Q1.15 samples, then streams every (k, n) pair of the DFT kernel e^(−j2πkn/N) to the CORDIC stage, k outer and n inner.
- For each pair it folds the angle into quadrant q and a residual, pre-rotates the sample by −q·90°, and emits the residual, so the CORDIC only sees |phi| ≤ π/4 (0x6488).

## Interface
- N, 64: frame length; power of two, 8 ≤ N ≤ 1024.
- LOG2N, $clog2(N): index width.
- STEP, 16'd3217: round(2π/N·2^15); the angle of one index step in radians, Q1.15.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer accepts a sample.
- s_x, s_y  in  16  sample real/imag, signed Q1.15.
- c_valid  out  1  CORDIC request valid.
- c_ready  in  1  CORDIC stage accepts the request.
- c_x, c_y  out  16  pre-rotated sample, signed Q1.15.
- c_phi  out  16  signed residual angle, Q1.15 radians. The CORDIC rotates by −c_phi.
- c_k  out  LOG2N  bin index of the request.
- c_last  out  1  high on the request with n = N−1.

## Operation
**States**
- LOAD:
  - s_ready = 1.
  - Each s_valid&&s_ready writes buffer[wr_n] and increments wr_n.
  - Accepting the sample with wr_n = N−1 moves to ISSUE with k = 0, n = 0, m = 0.
- ISSUE:
  - s_ready = 0.
  - The pipeline register advances when it is empty or c_ready = 1.
  - Each advance loads the current (k, n), then steps the counters:
    - n increments and m ← (m + k) mod N.
    - At n = N−1: n ← 0, m ← 0, k increments.
  - After the request with k = n = N−1 is loaded, no further loads occur.
  - The handshake of that final request returns the FSM to LOAD with wr_n = 0.

**Angle fold (per request)**
- m = k·n mod N is held as an accumulator; no multiplier.
- q = ((m + N/8) >> (LOG2N−2)) & 3.
- r = (m − q·N/4) mod N, read as LOG2N-bit two's complement. r lies in [−N/8, N/8).
- c_phi = r·STEP, formed in a 32-bit signed product, low 16 bits kept. Result lies in [−0x6488, 0x6488).

**Pre-rotation of buffer[n] = (x, y)**
- q = 0: (x, y).
- q = 1: (y, −x).
- q = 2: (−x, −y).
- q = 3: (−y, x).
- Any negation of −32768 saturates to 32767.

**Outputs**
- c_k = k, c_last = (n == N−1).
- Outputs hold stable while c_valid && !c_ready.

## Timing
- Reset: the FSM enters LOAD, wr_n, k, n and m clear to 0, and the buffer contents are don't-care.
- Reset values of the registered outputs: c_valid = 0, c_x = c_y = c_phi = 0, c_k = 0, c_last = 0.
- s_ready is 1 in the first cycle after rst deasserts.
- Reset in the middle of a frame or an ISSUE pass discards everything and returns to the reset state on the next edge.
- LOAD accepts 1 sample per cycle. No s_ready bubble between samples.
- If the last sample is accepted at edge E, the (0, 0) request is valid after edge E+1.
- Load-to-request latency is 1 cycle. With c_ready held at 1, throughput is 1 request per cycle, so N² requests take N² cycles.
- When c_ready = 0, the counters and the register hold; no request is dropped or duplicated.
- The cycle after the final handshake has c_valid = 0 and s_ready = 1.
- s_valid during ISSUE is ignored; s_ready stays 0.

## Structure
- Package dft_pkg holds:
  - the Q1.15 sample type;
  - PI_4_Q15 = 16'h6488;
  - the ISSUE/LOAD state enum;
  - the function sat_neg16 for saturating negation.
- Sub-module dft_sample_buffer:
  - N×32-bit register array;
  - one write port;
  - one combinational read port indexed by n.
- The top level holds the FSM, the k/n/m counters, the fold, the pre-rotation and the output register.

## Test plan
- Reset and first frame (N = 8, STEP = 25736), c_ready tied to 1:
  - Load 8 samples.
  - Expect 64 consecutive requests with c_k = 0..7, and c_last on every 8th request.
  - s_ready = 1 on the cycle after the last request.
- Fold, N = 8, sample n = 1 = (16384, 0):
  - k = 1 → c_x = 0, c_y = −16384, c_phi = 0x9B78.
  - k = 2 → c_x = 0, c_y = −16384, c_phi = 0.
  - k = 7 (m = 7, q = 0) → c_x = 16384, c_y = 0, c_phi = 0x9B78.
- Saturation: sample n = 1 = (−32768, 0), k = 4 (q = 2) → c_x = 32767, c_y = 0.
- Backpressure: toggle c_ready pseudo-randomly → the 64 requests arrive in order, none missing or repeated, and outputs are stable while stalled.
- Reset during ISSUE after request 20: pulse rst → c_valid = 0 and s_ready = 1 the next cycle; a new frame sequences from k = n = 0.
- s_valid held at 1 throughout ISSUE → no buffer write; the first frame's results are unchanged.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types and helpers for the DFT twiddle sequencer: Q1.15 sample format,
// FSM state encoding and saturating negation.
package dft_pkg;

  typedef logic signed [15:0] q15_t;

  typedef struct packed {
    q15_t x;
    q15_t y;
  } sample_t;

  localparam q15_t PI_4_Q15 = 16'h6488;

  typedef enum logic {
    ST_LOAD,
    ST_ISSUE
  } state_t;

  // -1.0 has no positive Q1.15 counterpart, so it clips to the largest value.
  function automatic q15_t sat_neg16(input q15_t v);
    return (v == 16'sh8000) ? 16'sh7fff : -v;
  endfunction

endpackage

// File: rtl/dft_sample_buffer.sv
// One-frame sample store: N x 32-bit registers, a single write port and a
// combinational read port.
module dft_sample_buffer
  import dft_pkg::*;
#(
  parameter int N     = 64,
  parameter int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [31:0]      rdata
);

  sample_t mem [N];

  // NOTE: the storage array has no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= sample_t'(wdata);
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dft_twiddle_sequencer.sv
// Buffers a frame of N samples, then streams every (k, n) DFT kernel pair to the
// CORDIC stage as a quadrant-pre-rotated sample plus a residual angle in [-pi/4, pi/4).
module dft_twiddle_sequencer
  import dft_pkg::*;
#(
  parameter int          N     = 64,
  parameter int          LOG2N = $clog2(N),
  parameter logic [15:0] STEP  = 16'd3217
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_x,
  input  logic [15:0]      s_y,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [15:0]      c_x,
  output logic [15:0]      c_y,
  output logic [15:0]      c_phi,
  output logic [LOG2N-1:0] c_k,
  output logic             c_last
);

  localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] EIGHTH  = LOG2N'(N / 8);

  state_t           state, state_nxt;
  logic [LOG2N-1:0] wr_n, k, n, m;
  logic             last_loaded;
  logic             accept, advance, final_hs;

  logic [31:0]       rd_word;
  q15_t              rd_x, rd_y, rot_x, rot_y;
  logic [1:0]        q;
  logic [LOG2N-1:0]  r;
  logic signed [31:0] r_ext, step_ext;
  q15_t              phi;

  dft_sample_buffer #(.N(N), .LOG2N(LOG2N)) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_n),
    .wdata ({s_x, s_y}),
    .raddr (n),
    .rdata (rd_word)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    final_hs  = 1'b0;
    case (state)
      ST_LOAD: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid && wr_n == IDX_MAX) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        advance  = !last_loaded && (!c_valid || c_ready);
        final_hs = last_loaded && c_valid && c_ready;
        if (final_hs) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // m tracks k*n mod N incrementally; LOG2N-bit wraparound is the modulo.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_n        <= '0;
      k           <= '0;
      n           <= '0;
      m           <= '0;
      last_loaded <= 1'b0;
    end else begin
      if (accept) wr_n <= wr_n + 1'b1;
      if (accept && wr_n == IDX_MAX) begin
        k           <= '0;
        n           <= '0;
        m           <= '0;
        last_loaded <= 1'b0;
      end
      if (advance) begin
        if (k == IDX_MAX && n == IDX_MAX) last_loaded <= 1'b1;
        if (n == IDX_MAX) begin
          n <= '0;
          m <= '0;
          k <= k + 1'b1;
        end else begin
          n <= n + 1'b1;
          m <= m + k;
        end
      end
    end
  end

  // Quadrant is the top two bits of m offset by an eighth turn; the residual
  // is what remains after removing q quarter turns, read as signed.
  always_comb begin
    q        = 2'((m + EIGHTH) >> (LOG2N - 2));
    r        = m - {q, {(LOG2N-2){1'b0}}};
    r_ext    = 32'(signed'(r));
    step_ext = {16'h0000, STEP};
    phi      = 16'(r_ext * step_ext);
    rd_x     = rd_word[31:16];
    rd_y     = rd_word[15:0];
    case (q)
      2'd0:    begin rot_x = rd_x;            rot_y = rd_y;            end
      2'd1:    begin rot_x = rd_y;            rot_y = sat_neg16(rd_x); end
      2'd2:    begin rot_x = sat_neg16(rd_x); rot_y = sat_neg16(rd_y); end
      default: begin rot_x = sat_neg16(rd_y); rot_y = rd_x;            end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_x     <= '0;
      c_y     <= '0;
      c_phi   <= '0;
      c_k     <= '0;
      c_last  <= 1'b0;
    end else if (advance) begin
      c_valid <= 1'b1;
      c_x     <= rot_x;
      c_y     <= rot_y;
      c_phi   <= phi;
      c_k     <= k;
      c_last  <= (n == IDX_MAX);
    end else if (c_ready) begin
      c_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dft_twiddle_sequencer.sv
// Directed bench for dft_twiddle_sequencer at N = 8: full passes, fold and
// saturation vectors, random backpressure, mid-pass reset and ignored s_valid.
module tb_dft_twiddle_sequencer;
  import dft_pkg::*;

  localparam int          N        = 8;
  localparam int          LOG2N    = 3;
  localparam logic [15:0] STEP     = 16'd25736;
  localparam int          STEP_INT = 25736;

  logic             clk, rst;
  logic             s_valid, s_ready;
  logic [15:0]      s_x, s_y;
  logic             c_valid, c_ready;
  logic [15:0]      c_x, c_y, c_phi;
  logic [LOG2N-1:0] c_k;
  logic             c_last;

  dft_twiddle_sequencer #(.N(N), .LOG2N(LOG2N), .STEP(STEP)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x     (s_x),
    .s_y     (s_y),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_x     (c_x),
    .c_y     (c_y),
    .c_phi   (c_phi),
    .c_k     (c_k),
    .c_last  (c_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] fa_x [N] = '{16'sd1000, 16'sd16384, -16'sd32768, 16'sd300,
                                   -16'sd1, 16'sd12345, -16'sd7, 16'sd32767};
  logic signed [15:0] fa_y [N] = '{-16'sd2000, 16'sd0, 16'sd5, -16'sd32768,
                                   16'sd1, -16'sd12345, 16'sd32767, -16'sd32768};
  logic signed [15:0] fb_x [N] = '{16'sd200, -16'sd32768, 16'sd77, -16'sd32768,
                                   16'sd5, 16'sd0, -16'sd100, 16'sd9};
  logic signed [15:0] fb_y [N] = '{16'sd400, 16'sd0, -16'sd32768, -16'sd32768,
                                   -16'sd5, 16'sd32767, 16'sd100, -16'sd9};

  logic signed [15:0] mdl_x [N];
  logic signed [15:0] mdl_y [N];
  logic [15:0] cap_x [N*N];
  logic [15:0] cap_y [N*N];
  logic [15:0] cap_phi [N*N];
  logic [15:0] lfsr = 16'hACE1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int neg_sat(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  // Reference: direct k*n product, integer quadrant split and rotation table.
  task automatic model(input int k, input int n, output logic [15:0] ex,
                       output logic [15:0] ey, output logic [15:0] ephi);
    int m, q, r, x, y, rx, ry;
    m = (k * n) % N;
    q = ((m + N/8) / (N/4)) % 4;
    r = m - q * (N/4);
    if (r >= N/2) r -= N;
    x = mdl_x[n];
    y = mdl_y[n];
    case (q)
      0:       begin rx = x;          ry = y;          end
      1:       begin rx = y;          ry = neg_sat(x); end
      2:       begin rx = neg_sat(x); ry = neg_sat(y); end
      default: begin rx = neg_sat(y); ry = x;          end
    endcase
    ex   = 16'(rx);
    ey   = 16'(ry);
    ephi = 16'(r * STEP_INT);
  endtask

  task automatic load_frame(input bit use_b);
    for (int i = 0; i < N; i++) begin
      mdl_x[i] = use_b ? fb_x[i] : fa_x[i];
      mdl_y[i] = use_b ? fb_y[i] : fa_y[i];
      s_valid  = 1'b1;
      s_x      = mdl_x[i];
      s_y      = mdl_y[i];
      check($sformatf("s_ready_load[%0d]", i), 32'(s_ready), 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // Consumes up to stop_after requests. mode 0: c_ready held high; mode 1: random.
  task automatic collect(input int mode, input int stop_after, input bit hold_sv);
    int idx = 0, cyc = 0, first_cyc = -1, last_cyc = -1, lim, p;
    bit stalled = 1'b0, rdy;
    logic [15:0] sv_x, sv_y, sv_phi, ex, ey, ephi;
    logic [LOG2N-1:0] sv_k;
    logic sv_last;
    lim = int'(PI_4_Q15);
    while (idx < stop_after && cyc < 2000) begin
      if (stalled) begin
        check("stall_valid", 32'(c_valid), 32'd1);
        check("stall_hold", {c_x, c_y}, {sv_x, sv_y});
        check("stall_hold_meta", {12'h0, c_phi, 1'b0, c_k, c_last},
              {12'h0, sv_phi, 1'b0, sv_k, sv_last});
      end
      if (hold_sv) begin
        s_valid = 1'b1;
        s_x     = 16'h1234;
        s_y     = 16'hBEEF;
      end
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rdy  = (mode == 0) ? 1'b1 : lfsr[0];
      c_ready = rdy;
      stalled = 1'b0;
      if (c_valid) begin
        if (rdy) begin
          model(idx / N, idx % N, ex, ey, ephi);
          check($sformatf("req%0d_k", idx), 32'(c_k), 32'(idx / N));
          check($sformatf("req%0d_last", idx), 32'(c_last), 32'((idx % N) == N - 1));
          check($sformatf("req%0d_xy", idx), {c_x, c_y}, {ex, ey});
          check($sformatf("req%0d_phi", idx), 32'(c_phi), 32'(ephi));
          p = int'($signed(c_phi));
          check($sformatf("req%0d_phi_range", idx), 32'(p >= -lim && p < lim), 32'd1);
          cap_x[idx]   = c_x;
          cap_y[idx]   = c_y;
          cap_phi[idx] = c_phi;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          idx++;
        end else begin
          stalled = 1'b1;
          sv_x = c_x; sv_y = c_y; sv_phi = c_phi; sv_k = c_k; sv_last = c_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    if (idx < stop_after) check("collect_timeout", 32'(idx), 32'(stop_after));
    if (stop_after == N * N) begin
      check("post_c_valid", 32'(c_valid), 32'd0);
      check("post_s_ready", 32'(s_ready), 32'd1);
      if (mode == 0) begin
        check("first_latency", 32'(first_cyc), 32'd1);
        check("burst_span", 32'(last_cyc - first_cyc), 32'(N * N - 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; c_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c_valid", 32'(c_valid), 32'd0);
    check("rst_c_xy", {c_x, c_y}, 32'd0);
    check("rst_c_phi", 32'(c_phi), 32'd0);
    check("rst_c_k_last", {28'h0, c_k, c_last}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", 32'(s_ready), 32'd1);

    // First frame, c_ready high: fold vectors checked by hand.
    load_frame(1'b0);
    collect(0, N * N, 1'b0);
    check("fold_k1", {cap_x[9], cap_y[9]}, {16'h0000, 16'hC000});
    check("fold_k1_phi", 32'(cap_phi[9]), 32'h9B78);
    check("fold_k2", {cap_x[17], cap_y[17]}, {16'h0000, 16'hC000});
    check("fold_k2_phi", 32'(cap_phi[17]), 32'h0000);
    check("fold_k7", {cap_x[57], cap_y[57]}, {16'h4000, 16'h0000});
    check("fold_k7_phi", 32'(cap_phi[57]), 32'h9B78);

    // Second frame with s_valid held high through ISSUE; saturation at k=4.
    load_frame(1'b1);
    collect(0, N * N, 1'b1);
    check("sat_k4", {cap_x[33], cap_y[33]}, {16'h7FFF, 16'h0000});

    // Random backpressure.
    load_frame(1'b0);
    collect(1, N * N, 1'b0);

    // Reset after request 20, then a fresh frame from k = n = 0.
    load_frame(1'b1);
    collect(0, 21, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_c_valid", 32'(c_valid), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    load_frame(1'b0);
    collect(0, N * N, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
